dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Data-memory responder (slave end) of the core's load/store interface.
- Accepts one load/store request at a time from the LSU: 32-bit address, 32-bit write data, byte/half/word size.
- Performs the access on an internal word-organised RAM after a programmable wait.
- Returns a one-cycle response carrying the extended load data, or an error flag plus an exception code.

Parameters:
DEPTH_WORDS, 1024, RAM depth in 32-bit words (power of two, >=4)
BASE_ADDR, 32'h0000_0000, byte address of word 0 (word-aligned)
WAIT_CYCLES, 1, extra cycles between accept and RAM access (0..15)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
req_i  in  1  request valid
we_i  in  1  1=store, 0=load
addr_i  in  32  byte address
wdata_i  in  32  store data, right-justified (byte in [7:0], half in [15:0])
size_i  in  2  00 byte, 01 half, 10 word, 11 reserved
unsigned_i  in  1  loads: 1 zero-extend, 0 sign-extend
ready_o  out  1  responder can accept a request
rvalid_o  out  1  response valid, single-cycle pulse
rdata_o  out  32  load result; 0 for stores and errors
err_o  out  1  response is an error (qualified by rvalid_o)
excode_o  out  8  exception code (qualified by rvalid_o & err_o)

Behaviour:
- Reset: state IDLE; ready_o=0 while rst=1, then 1 in IDLE. rvalid_o=0, rdata_o=0, err_o=0, excode_o=0. RAM contents are not reset.
- Handshake: request accepted on an edge where req_i & ready_o. addr/we/wdata/size/unsigned are latched on acceptance. ready_o=1 only in IDLE. Inputs are ignored when not accepted.
- Error check at acceptance, evaluated in this priority order:
  1. misaligned: half with addr[0]=1, or word with addr[1:0]!=0 -> excode 8'h04 (load) / 8'h06 (store).
  2. else size 11, or address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS) -> excode 8'h05 (load) / 8'h07 (store).
- FSM, states IDLE, WAIT, RESP:
  - IDLE: accept with error -> RESP (no RAM access, no wait). Accept OK and WAIT_CYCLES=0 -> RESP with access. Accept OK and WAIT_CYCLES>0 -> WAIT, counter loaded with WAIT_CYCLES-1.
  - WAIT: counter decrements; at 0 -> RESP with access.
  - RESP: rvalid_o=1 for exactly one cycle -> IDLE.
- Latency: accept edge N -> rvalid_o high in cycle N+1+WAIT_CYCLES. Errors: cycle N+1. Max throughput is one request per 2+WAIT_CYCLES cycles.
- Access is performed on the edge entering RESP:
  - Store writes only enabled lanes. Byte: lane addr[1:0], data wdata[7:0]. Half: lanes addr[1]*2+{0,1}, data wdata[15:0]. Word: all four lanes.
  - Load: registered rdata_o = selected lane(s) shifted to bit 0, then sign- or zero-extended per unsigned_i. unsigned_i is ignored for word.
- Error and store responses drive rdata_o=0. A successful response drives err_o=0, excode_o=0. Outputs hold their values outside RESP; only rvalid_o qualifies them.
- Reset mid-operation: rst overrides everything. A store accepted but not yet at its RESP-entry edge is dropped: no RAM write, no response. rst asserted on the RESP-entry edge also blocks the write.
- Address wrap: no wrap. BASE_ADDR+4*DEPTH_WORDS and above is an access fault. Index arithmetic is (addr-BASE_ADDR)>>2, 32-bit.

Optional Feature:
- Macro: DMEM_PERF_CNT_EN.
- Defined: adds outputs load_cnt_o, store_cnt_o, err_cnt_o (32 bits each).
  - Counts accepted loads, accepted stores, and error responses.
  - A load or store is counted at acceptance, errors included.
  - Counters increment with modulo 2^32 wrap and reset to 0.
  - If rst occurs mid-transaction, counts already taken remain.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
1. WAIT_CYCLES=1: store word 0xDEADBEEF @0x10, then load word @0x10 -> each rvalid_o 2 cycles after accept; load rdata_o=0xDEADBEEF, err_o=0.
2. After 1: load byte @0x13 signed -> 0xFFFFFFDE; unsigned -> 0x000000DE; load half @0x12 signed -> 0xFFFFDEAD.
3. Store byte 0x55 @0x11 (wdata_i=0xAAAAAA55) -> load word @0x10 = 0xDEAD55EF.
4. Load half @0x11 -> rvalid_o 1 cycle after accept, err_o=1, excode_o=0x04, rdata_o=0. Store word @0x12 -> excode_o=0x06, RAM unchanged. size_i=11 load -> 0x05.
5. Load word @BASE_ADDR+4*DEPTH_WORDS -> err_o=1, excode_o=0x05. Store there -> 0x07.
6. WAIT_CYCLES=3: store 0x12345678 @0x20, rst pulsed 2 cycles after accept -> no rvalid_o, word @0x20 unchanged, ready_o=1 the cycle after rst drops.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: one LSU load/store at a time on a word RAM, with a response after 1+WAIT_CYCLES cycles (errors after 1).
// ready_o is high only in IDLE, so the LSU stalls until the response. `define DMEM_PERF_CNT_EN adds load/store/error counters.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic        ready_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic [7:0]  excode_o
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0] load_cnt_o,
  output logic [31:0] store_cnt_o,
  output logic [31:0] err_cnt_o
`endif
);

  localparam int unsigned IW    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WLOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam bit          NO_WAIT = (WAIT_CYCLES == 0);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [31:0] r_mem [DEPTH_WORDS];

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [7:0]  r_exc;

  logic        w_accept;
  logic [31:0] w_off;
  logic        w_mis;
  logic        w_flt;
  logic        w_err;
  logic [7:0]  w_exc;

  assign ready_o  = !rst && (r_state == ST_IDLE);
  assign rvalid_o = (r_state == ST_RESP);
  assign rdata_o  = r_rdata;
  assign err_o    = r_err;
  assign excode_o = r_exc;

  // Error classification on the live request; misalignment outranks size/range faults.
  assign w_accept = req_i && ready_o;
  assign w_off    = addr_i - BASE_ADDR;
  assign w_mis    = ((size_i == SZ_HALF) && addr_i[0]) ||
                    ((size_i == SZ_WORD) && (addr_i[1:0] != 2'b00));
  assign w_flt    = (size_i == 2'b11) || ({1'b0, w_off} >= LIMIT);
  assign w_err    = w_mis || w_flt;
  assign w_exc    = w_mis ? (we_i ? 8'h06 : 8'h04) : (we_i ? 8'h07 : 8'h05);

  // With no wait the access uses the live inputs; otherwise the latched copy.
  logic          w_a_we;
  logic [31:0]   w_a_addr;
  logic [31:0]   w_a_wdata;
  logic [1:0]    w_a_size;
  logic          w_a_uns;
  logic          w_access;
  logic [31:0]   w_a_off;
  logic [IW-1:0] w_idx;
  logic [1:0]    w_lane;
  logic [31:0]   w_word;
  logic [7:0]    w_b;
  logic [15:0]   w_h;
  logic [31:0]   w_load;
  logic [3:0]    w_be;
  logic [31:0]   w_wd;

  assign w_a_we    = (r_state == ST_IDLE) ? we_i       : r_we;
  assign w_a_addr  = (r_state == ST_IDLE) ? addr_i     : r_addr;
  assign w_a_wdata = (r_state == ST_IDLE) ? wdata_i    : r_wdata;
  assign w_a_size  = (r_state == ST_IDLE) ? size_i     : r_size;
  assign w_a_uns   = (r_state == ST_IDLE) ? unsigned_i : r_uns;

  assign w_access = !rst &&
                    (((r_state == ST_IDLE) && w_accept && !w_err && NO_WAIT) ||
                     ((r_state == ST_WAIT) && (r_cnt == 4'd0)));

  assign w_a_off = w_a_addr - BASE_ADDR;
  assign w_idx   = IW'(w_a_off >> 2);
  assign w_lane  = w_a_addr[1:0];
  assign w_word  = r_mem[w_idx];
  assign w_b     = 8'(w_word >> {w_lane, 3'b000});
  assign w_h     = 16'(w_word >> {w_lane[1], 4'b0000});

  always_comb begin
    w_load = w_word;
    w_be   = 4'b1111;
    w_wd   = w_a_wdata;
    case (w_a_size)
      SZ_BYTE: begin
        w_load = {{24{w_b[7] & ~w_a_uns}}, w_b};
        w_be   = 4'b0001 << w_lane;
        w_wd   = {4{w_a_wdata[7:0]}};
      end
      SZ_HALF: begin
        w_load = {{16{w_h[15] & ~w_a_uns}}, w_h};
        w_be   = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wd   = {2{w_a_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_access && w_a_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
      r_exc   <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_we    <= we_i;
            r_addr  <= addr_i;
            r_wdata <= wdata_i;
            r_size  <= size_i;
            r_uns   <= unsigned_i;
            if (w_err) begin
              r_state <= ST_RESP;
              r_rdata <= 32'd0;
              r_err   <= 1'b1;
              r_exc   <= w_exc;
            end else if (NO_WAIT) begin
              r_state <= ST_RESP;
              r_rdata <= we_i ? 32'd0 : w_load;
              r_err   <= 1'b0;
              r_exc   <= 8'd0;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= WLOAD;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_RESP;
            r_rdata <= r_we ? 32'd0 : w_load;
            r_err   <= 1'b0;
            r_exc   <= 8'd0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef DMEM_PERF_CNT_EN
  logic [31:0] r_load_cnt;
  logic [31:0] r_store_cnt;
  logic [31:0] r_err_cnt;

  assign load_cnt_o  = r_load_cnt;
  assign store_cnt_o = r_store_cnt;
  assign err_cnt_o   = r_err_cnt;

  // An accepted error always produces its response on the next cycle, so it is counted here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_load_cnt  <= 32'd0;
      r_store_cnt <= 32'd0;
      r_err_cnt   <= 32'd0;
    end else if (w_accept) begin
      if (we_i) r_store_cnt <= r_store_cnt + 32'd1;
      else      r_load_cnt  <= r_load_cnt + 32'd1;
      if (w_err) r_err_cnt <= r_err_cnt + 32'd1;
    end
  end
`endif

endmodule
